vid_dma: RTL and testbench

Video DMA fetch engine acting as a Wishbone read master in front of the SDRAM controller. It walks a circular screen buffer defined by start/end/init addresses and fetches 64-bit word pairs as two-beat incrementing bursts. Fetched words go into a first-word-fall-through FIFO, which the video pixel pipeline drains one 32-bit word at a time. Frame sync reloads the fetch pointer and flushes the FIFO.

---
 rtl/vid_dma.sv | 155 +++++++++++++++
 tb/tb_vid_dma.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_dma.sv
// Video DMA fetch engine: walks a circular screen buffer with two-beat Wishbone read bursts
// and feeds a first-word-fall-through FIFO drained 32 bits at a time by the pixel pipeline.
module vid_dma #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  enable,
  input  logic [23:0]           vid_start,
  input  logic [23:0]           vid_end,
  input  logic [23:0]           vid_init,
  input  logic                  frame_sync,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow,
  output logic [23:0]           wb_adr,
  output logic [2:0]            wb_cti,
  output logic [3:0]            wb_sel,
  output logic                  wb_we,
  output logic                  wb_stb,
  output logic                  wb_cyc,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack
);

  localparam int unsigned LvlW  = DEPTH_LOG2 + 1;
  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  state_e                r_state;
  logic [20:0]           r_ptr;
  logic                  r_discard;
  logic                  r_cyc;
  logic [23:0]           r_adr;
  logic [2:0]            r_cti;
  logic [31:0]           r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [LvlW-1:0]       r_level;
  logic                  r_empty;
  logic [31:0]           r_rd_data;
  logic                  r_underflow;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_launch;
  logic [DEPTH_LOG2-1:0] w_rptr_nxt;
  logic [DEPTH_LOG2-1:0] w_wptr_nxt;
  logic [LvlW-1:0]       w_level_nxt;
  logic [31:0]           w_rd_nxt;
  logic [20:0]           w_ptr_adv;

  // In IDLE nothing is in flight, so free space is simply Depth - level.
  assign w_launch = enable & ~frame_sync & (r_level <= LvlW'(Depth - 2));
  assign w_push   = (r_state != StIdle) & wb_ack & ~r_discard & ~frame_sync;
  assign w_pop    = rd_en & (r_level != '0);

  always_comb begin
    w_rptr_nxt  = r_rptr + DEPTH_LOG2'(w_pop);
    w_wptr_nxt  = r_wptr + DEPTH_LOG2'(w_push);
    w_level_nxt = r_level + LvlW'(w_push) - LvlW'(w_pop);
    w_ptr_adv   = (r_ptr == vid_end[23:3]) ? vid_start[23:3] : r_ptr + 21'd1;
    w_rd_nxt    = r_rd_data;
    // New head may be the word being written on this very edge.
    if (w_level_nxt != '0) begin
      if (w_push && (w_rptr_nxt == r_wptr)) w_rd_nxt = wb_dat_i;
      else                                  w_rd_nxt = r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wptr] <= wb_dat_i;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_empty     <= 1'b1;
      r_rd_data   <= '0;
      r_underflow <= 1'b0;
    end else if (frame_sync) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_empty     <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_level   <= w_level_nxt;
      r_empty   <= (w_level_nxt == '0);
      r_rd_data <= w_rd_nxt;
      if (rd_en && (r_level == '0)) r_underflow <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state   <= StIdle;
      r_ptr     <= '0;
      r_discard <= 1'b0;
      r_cyc     <= 1'b0;
      r_adr     <= '0;
      r_cti     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_discard <= 1'b0;
          if (w_launch) begin
            r_cyc   <= 1'b1;
            r_adr   <= {r_ptr, 3'b000};
            r_cti   <= 3'b010;
            r_state <= StBeat0;
          end
        end
        StBeat0: begin
          if (frame_sync) r_discard <= 1'b1;
          if (wb_ack) begin
            r_adr[2] <= 1'b1;
            r_cti    <= 3'b111;
            r_state  <= StBeat1;
          end
        end
        StBeat1: begin
          if (frame_sync) r_discard <= 1'b1;
          if (wb_ack) begin
            r_cyc   <= 1'b0;
            r_state <= StIdle;
            if (!frame_sync && !r_discard) r_ptr <= w_ptr_adv;
          end
        end
        default: r_state <= StIdle;
      endcase
      // A burst that cannot be aborted still lets the frame restart at vid_init.
      if (frame_sync) r_ptr <= vid_init[23:3];
    end
  end

  assign rd_data   = r_rd_data;
  assign empty     = r_empty;
  assign level     = r_level;
  assign underflow = r_underflow;
  assign wb_adr    = r_adr;
  assign wb_cti    = r_cti;
  assign wb_sel    = 4'b1111;
  assign wb_we     = 1'b0;
  assign wb_stb    = r_cyc;
  assign wb_cyc    = r_cyc;

endmodule

// File: tb/tb_vid_dma.sv
// Randomised bench for vid_dma: a queue-based model of the fetch engine and FIFO is checked
// against the DUT every cycle, plus directed scenarios pinned with literal expectations.
module tb_vid_dma;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] vid_start = '0;
  logic [23:0] vid_end = '0;
  logic [23:0] vid_init = '0;
  logic        frame_sync = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        empty;
  logic [4:0]  level;
  logic        underflow;
  logic [23:0] wb_adr;
  logic [2:0]  wb_cti;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;

  vid_dma #(.DEPTH_LOG2(4)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .vid_start(vid_start),
    .vid_end(vid_end), .vid_init(vid_init), .frame_sync(frame_sync), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .level(level), .underflow(underflow),
    .wb_adr(wb_adr), .wb_cti(wb_cti), .wb_sel(wb_sel), .wb_we(wb_we), .wb_stb(wb_stb),
    .wb_cyc(wb_cyc), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
  );

  always #5 wb_clk = ~wb_clk;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  logic [31:0] mq[$];
  logic [31:0] m_rd = '0;
  bit          m_uf = 0;
  logic [20:0] m_ptr = '0;
  int          m_beats = 0;
  bit          m_disc = 0;
  logic [23:0] m_badr = '0;
  logic [23:0] launches[$];

  // Slave state
  int s_phase = 0;
  int s_cnt = 0;
  int lat = 5;
  bit rand_lat = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int pre;
    bit busy;
    bit push;
    bit pop_ok;
    bit disc_old;
    if (wb_rst) begin
      mq.delete();
      m_rd = '0; m_uf = 0; m_ptr = '0; m_beats = 0; m_disc = 0;
      return;
    end
    pre = mq.size();
    busy = (m_beats != 0);
    disc_old = m_disc;
    push = busy && wb_ack && !frame_sync && !m_disc;
    if (!busy) begin
      m_disc = 0;
      if (enable && (16 - pre) >= 2 && !frame_sync) begin
        m_beats = 2;
        m_badr = {m_ptr, 3'b000};
        launches.push_back(m_badr);
      end
    end else begin
      if (frame_sync) m_disc = 1;
      if (wb_ack) begin
        if (m_beats == 2) m_beats = 1;
        else begin
          m_beats = 0;
          if (!frame_sync && !disc_old)
            m_ptr = (m_ptr == vid_end[23:3]) ? vid_start[23:3] : m_ptr + 21'd1;
        end
      end
    end
    if (frame_sync) m_ptr = vid_init[23:3];
    if (frame_sync) begin
      mq.delete();
      m_uf = 0;
    end else begin
      pop_ok = rd_en && pre > 0;
      if (rd_en && pre == 0) m_uf = 1;
      if (push) mq.push_back(wb_dat_i);
      if (pop_ok) void'(mq.pop_front());
      if (mq.size() > 0) m_rd = mq[0];
    end
  endtask

  task automatic compare_all();
    bit busy;
    busy = (m_beats != 0);
    chk("wb_cyc", wb_cyc, busy);
    chk("wb_stb", wb_stb, busy);
    if (busy) begin
      chk("wb_adr", wb_adr, (m_beats == 2) ? m_badr : (m_badr | 24'h4));
      chk("wb_cti", wb_cti, (m_beats == 2) ? 3'b010 : 3'b111);
    end
    chk("rd_data", rd_data, m_rd);
    chk("empty", empty, mq.size() == 0);
    chk("level", level, mq.size());
    chk("underflow", underflow, m_uf);
  endtask

  // One clock: slave responds to current bus outputs, edge, model update, compare.
  task automatic cycle();
    if (wb_rst || wb_cyc !== 1'b1) begin
      s_phase = 0; s_cnt = 0; wb_ack = 0;
    end else begin
      case (s_phase)
        0: begin
          if (rand_lat && s_cnt == 0) lat = $urandom_range(1, 6);
          s_cnt++;
          if (s_cnt >= lat) begin
            wb_ack = 1; wb_dat_i = {8'h00, wb_adr}; s_phase = 1;
          end else wb_ack = 0;
        end
        1: begin
          wb_ack = 1; wb_dat_i = {8'h00, wb_adr}; s_phase = 2;
        end
        default: wb_ack = 0;
      endcase
    end
    @(posedge wb_clk);
    #1;
    model_edge();
    @(negedge wb_clk);
    compare_all();
    frame_sync = 0;
    wb_rst = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_beats(input int b, input int budget, input string nm);
    int n = 0;
    while (m_beats != b && n < budget) begin
      cycle();
      n++;
    end
    chk(nm, m_beats, b);
  endtask

  initial begin
    int n0;
    logic [31:0] popped[$];
    logic [31:0] saved;

    // Reset
    wb_rst = 1;
    cycle();
    wb_rst = 1;
    cycle();
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_cti", wb_cti, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_rd", rd_data, 0);
    chk("sel", wb_sel, 4'hF);
    chk("we", wb_we, 0);

    // Circular fill with no pops
    vid_start = 24'h001000; vid_init = 24'h001000; vid_end = 24'h001018;
    frame_sync = 1;
    cycle();
    enable = 1;
    lat = 5;
    run(150);
    chk("fill_bursts", launches.size(), 8);
    chk("fill_l0", launches[0], 24'h001000);
    chk("fill_l1", launches[1], 24'h001008);
    chk("fill_l2", launches[2], 24'h001010);
    chk("fill_l3", launches[3], 24'h001018);
    chk("fill_l4", launches[4], 24'h001000);
    chk("fill_level", level, 16);
    chk("fill_cyc", wb_cyc, 0);

    // Pops return address-valued data in order
    n0 = 0;
    while (popped.size() < 16 && n0 < 400) begin
      rd_en = !empty;
      if (!empty) popped.push_back(rd_data);
      cycle();
      n0++;
    end
    rd_en = 0;
    chk("pop_count", popped.size(), 16);
    for (int i = 0; i < 16; i++) chk("pop_data", popped[i], 32'h1000 + 32'(4 * (i % 8)));

    // Steady pop every cycle with 4-cycle latency drives underflow
    lat = 4;
    rd_en = 1;
    run(60);
    rd_en = 0;
    chk("uf_set", underflow, 1);
    frame_sync = 1;
    cycle();
    chk("uf_clr", underflow, 0);

    // frame_sync in BEAT0: burst completes, words discarded, restart at vid_init
    vid_init = 24'h002000;
    wait_beats(2, 60, "wait_beat0");
    frame_sync = 1;
    n0 = launches.size();
    cycle();
    while (m_beats != 0 && total < 1000000) begin
      chk("fs_level0", level, 0);
      cycle();
    end
    chk("fs_level_after", level, 0);
    for (int i = 0; i < 20 && launches.size() <= n0; i++) cycle();
    chk("fs_next_count", launches.size(), n0 + 1);
    chk("fs_next_adr", launches[n0], 24'h002000);

    // Pop on empty
    enable = 0;
    wait_beats(0, 60, "wait_idle");
    frame_sync = 1;
    cycle();
    saved = rd_data;
    rd_en = 1;
    cycle();
    rd_en = 0;
    chk("empty_pop_rd", rd_data, saved);
    chk("empty_pop_uf", underflow, 1);

    // Reset mid-burst
    enable = 1;
    wait_beats(1, 60, "wait_beat1");
    wb_rst = 1;
    cycle();
    chk("mrst_cyc", wb_cyc, 0);
    chk("mrst_adr", wb_adr, 0);
    chk("mrst_cti", wb_cti, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_level", level, 0);
    chk("mrst_uf", underflow, 0);
    chk("mrst_rd", rd_data, 0);

    // Pointer wrap modulo 2^21
    enable = 0;
    wait_beats(0, 60, "wait_idle2");
    vid_init = 24'hFFFFF8; vid_end = 24'h000000; vid_start = 24'h000100;
    frame_sync = 1;
    cycle();
    n0 = launches.size();
    enable = 1;
    for (int i = 0; i < 300 && launches.size() < n0 + 3; i++) cycle();
    chk("wrap_count", launches.size(), n0 + 3);
    chk("wrap_l0", launches[n0], 24'hFFFFF8);
    chk("wrap_l1", launches[n0 + 1], 24'h000000);
    chk("wrap_l2", launches[n0 + 2], 24'h000100);

    // Random traffic against the model
    rand_lat = 1;
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      rd_en = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) begin
        frame_sync = 1;
        vid_init = 24'($urandom_range(0, 24'hFFFFFF));
        vid_start = {8'h00, 13'($urandom_range(0, 8191)), 3'($urandom_range(0, 7))};
        vid_end = vid_start + 24'(8 * $urandom_range(0, 5));
      end
      if ($urandom_range(0, 599) == 0) wb_rst = 1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
